// File: rtl/tracker_clk_pkg.sv
// Shared definitions for the tracker clock-enable generator.
//   lock_state_e    : lock-qualification FSM states
//   DIV_W_DEF       : default divide-ratio width
//   LOCK_CYCLES_DEF : default number of lock-high cycles before READY
//   ch_w()          : channel-index width for a given channel count (min 1)
package tracker_clk_pkg;

  localparam int unsigned DIV_W_DEF       = 16;
  localparam int unsigned LOCK_CYCLES_DEF = 256;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    QUALIFY,
    RUN
  } lock_state_e;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tracker_clkgen_if.sv
// Divide-ratio configuration bus.
//   CFG_VALID : write request (master -> slave)
//   CFG_READY : slave can take the write for CFG_CH
//   CFG_CH    : target channel index
//   CFG_DIV   : new divide ratio, 0 disables the channel
interface tracker_clkgen_if
  import tracker_clk_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = DIV_W_DEF
);
  localparam int unsigned CH_W = ch_w(NUM_CH);

  logic             CFG_VALID;
  logic             CFG_READY;
  logic [CH_W-1:0]  CFG_CH;
  logic [DIV_W-1:0] CFG_DIV;

  modport master (output CFG_VALID, CFG_CH, CFG_DIV, input CFG_READY);
  modport slave  (input CFG_VALID, CFG_CH, CFG_DIV, output CFG_READY);
endinterface

// File: rtl/tracker_clkgen_ch.sv
// One clock-enable channel: down-counter, active ratio, one pending slot.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_run        : lock FSM is in RUN
//   i_sync       : phase realign strobe
//   i_wr, i_div  : accepted write of a new ratio to this channel
//   o_pend       : pending slot occupied
//   o_clken      : one-cycle pulse at terminal count
//   o_toggle     : square wave, period 2*DIV
module tracker_clkgen_ch
  import tracker_clk_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_pend,
  output logic             o_clken,
  output logic             o_toggle
);

  logic [DIV_W-1:0] r_cnt, r_act, r_pend;
  logic             r_pend_v, r_clken, r_toggle;
  logic             w_idle, w_term, w_apply;
  logic [DIV_W-1:0] w_act_nxt, w_reload;

  always_comb begin
    // idle: not counting this cycle (outside RUN, realign, or disabled)
    w_idle    = !i_run || i_sync || (r_act == '0);
    w_term    = !w_idle && (r_cnt == '0);
    // pending ratio only takes effect at a period boundary
    w_apply   = r_pend_v && (w_idle || w_term);
    w_act_nxt = w_apply ? r_pend : r_act;
    w_reload  = (w_act_nxt == '0) ? '0 : w_act_nxt - DIV_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_act    <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_clken  <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      // write is only accepted with an empty slot, so it never races an apply
      if (w_apply) begin
        r_act    <= r_pend;
        r_pend_v <= 1'b0;
      end else if (i_wr) begin
        r_pend   <= i_div;
        r_pend_v <= 1'b1;
      end

      if (w_idle) begin
        r_cnt    <= w_reload;
        r_clken  <= 1'b0;
        r_toggle <= 1'b0;
      end else if (w_term) begin
        r_cnt    <= w_reload;
        r_clken  <= 1'b1;
        r_toggle <= ~r_toggle;
      end else begin
        r_cnt    <= r_cnt - DIV_W'(1);
        r_clken  <= 1'b0;
      end
    end
  end

  // masked so nothing leaks out on the cycle READY falls
  assign o_pend   = r_pend_v;
  assign o_clken  = r_clken & i_run;
  assign o_toggle = r_toggle & i_run;

endmodule

// File: rtl/tracker_clkgen.sv
// Lock-qualified multi-channel clock-enable generator.
//   REFERENCECLK : sole clock (PLL output), rising edge
//   RESET        : synchronous active-high reset
//   PLL_LOCK     : raw lock indication
//   SYNC         : phase realign strobe for all channels
//   cfg          : divide-ratio configuration bus (slave)
//   READY        : lock qualified, channels running
//   CLKEN        : per-channel terminal-count pulse
//   TOGGLE       : per-channel square wave
//   LOL          : sticky loss-of-lock, only with TRACKER_CLKGEN_LOCKMON_EN
//                  (cleared by a write with CFG_CH all-ones and CFG_DIV 0)
module tracker_clkgen
  import tracker_clk_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic              REFERENCECLK,
  input  logic              RESET,
  input  logic              PLL_LOCK,
  input  logic              SYNC,
  tracker_clkgen_if.slave   cfg,
  output logic              READY,
  output logic [NUM_CH-1:0] CLKEN,
  output logic [NUM_CH-1:0] TOGGLE
`ifdef TRACKER_CLKGEN_LOCKMON_EN
  ,
  output logic              LOL
`endif
);

  localparam int unsigned CH_W = ch_w(NUM_CH);
  localparam int unsigned QW   = $clog2(LOCK_CYCLES + 1);

  lock_state_e          r_state, w_state_nxt;
  logic [QW-1:0]        r_qcnt, w_qcnt_nxt, w_qinc;
  logic                 r_ready;
  logic [NUM_CH-1:0]    w_pend, w_wr;
  logic [(2**CH_W)-1:0] w_busy;
  logic                 w_cfg_ready, w_acc;

  // WAIT_LOCK holds the counter at 0, so both pre-RUN states share one increment
  always_comb begin
    w_state_nxt = r_state;
    w_qcnt_nxt  = r_qcnt;
    w_qinc      = r_qcnt + QW'(1);
    case (r_state)
      WAIT_LOCK, QUALIFY: begin
        if (!PLL_LOCK) begin
          w_state_nxt = WAIT_LOCK;
          w_qcnt_nxt  = '0;
        end else begin
          w_qcnt_nxt  = w_qinc;
          w_state_nxt = (w_qinc == QW'(LOCK_CYCLES)) ? RUN : QUALIFY;
        end
      end
      RUN: begin
        if (!PLL_LOCK) begin
          w_state_nxt = WAIT_LOCK;
          w_qcnt_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = WAIT_LOCK;
        w_qcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      r_state <= WAIT_LOCK;
      r_qcnt  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_qcnt  <= w_qcnt_nxt;
      r_ready <= (w_state_nxt == RUN);
    end
  end

  assign READY = r_ready;

  // out-of-range channels read as never busy, so their writes are taken and dropped
  always_comb begin
    w_busy              = '0;
    w_busy[NUM_CH-1:0]  = w_pend;
    w_cfg_ready         = !w_busy[cfg.CFG_CH];
    w_acc               = cfg.CFG_VALID && w_cfg_ready;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_wr[i] = w_acc && (cfg.CFG_CH == CH_W'(i));
    end
  end

  assign cfg.CFG_READY = w_cfg_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tracker_clkgen_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .i_clk    (REFERENCECLK),
      .i_rst    (RESET),
      .i_run    (r_ready),
      .i_sync   (SYNC),
      .i_wr     (w_wr[g]),
      .i_div    (cfg.CFG_DIV),
      .o_pend   (w_pend[g]),
      .o_clken  (CLKEN[g]),
      .o_toggle (TOGGLE[g])
    );
  end

`ifdef TRACKER_CLKGEN_LOCKMON_EN
  logic r_lol;

  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      r_lol <= 1'b0;
    end else if (r_ready && (w_state_nxt != RUN)) begin
      r_lol <= 1'b1;
    end else if (w_acc && (&cfg.CFG_CH) && (cfg.CFG_DIV == '0)) begin
      r_lol <= 1'b0;
    end
  end

  assign LOL = r_lol;
`endif

endmodule

// File: tb/tb_tracker_clkgen.sv
// Scoreboard bench for tracker_clkgen. The stimulus process drives one cycle,
// pushes the reference model's expected outputs for that cycle and advances
// the model; a negedge monitor pops and compares. The model tracks lock as a
// run of consecutive lock samples and each channel as the absolute cycle of
// its next enable pulse.
module tb_tracker_clkgen;
  import tracker_clk_pkg::*;

  localparam int unsigned NCH = 6;
  localparam int unsigned DW  = 16;
  localparam int unsigned LCY = 256;
  localparam int unsigned CW  = ch_w(NCH);

  logic           clk = 1'b0;
  logic           rst, lock, sync_s;
  logic           ready;
  logic [NCH-1:0] clken, toggle;
`ifdef TRACKER_CLKGEN_LOCKMON_EN
  logic           lol;
`endif

  always #5 clk = ~clk;

  tracker_clkgen_if #(.NUM_CH(NCH), .DIV_W(DW)) cfg_if ();

  tracker_clkgen #(
    .NUM_CH      (NCH),
    .DIV_W       (DW),
    .LOCK_CYCLES (LCY)
  ) dut (
    .REFERENCECLK (clk),
    .RESET        (rst),
    .PLL_LOCK     (lock),
    .SYNC         (sync_s),
    .cfg          (cfg_if),
    .READY        (ready),
    .CLKEN        (clken),
    .TOGGLE       (toggle)
`ifdef TRACKER_CLKGEN_LOCKMON_EN
    ,
    .LOL          (lol)
`endif
  );

  typedef struct packed {
    logic           ready;
    logic [NCH-1:0] clken;
    logic [NCH-1:0] toggle;
    logic           cfg_ready;
    logic           lol;
  } exp_t;

  exp_t        q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // reference model state
  int unsigned m_act[NCH];
  int unsigned m_pend[NCH];
  bit          m_pv[NCH];
  bit          m_tog[NCH];
  bit          m_ck[NCH];
  longint      m_due[NCH];
  int unsigned m_lc;
  bit          m_ready, m_lol;
  longint      t = 0;

  function automatic bit m_cfg_ready(input int unsigned ch);
    return (ch < NCH) ? !m_pv[ch] : 1'b1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 0; m_pend[c] = 0; m_pv[c] = 0;
      m_tog[c] = 0; m_ck[c] = 0;   m_due[c] = 0;
    end
    m_lc = 0; m_ready = 0; m_lol = 0;
  endtask

  // one rising edge at the end of cycle t
  task automatic model_edge(input bit r, input bit lk, input bit sy, input bit vl,
                            input int unsigned ch, input int unsigned dv);
    bit acc, run, nrdy;
    if (r) begin
      model_reset();
      t++;
      return;
    end
    acc  = vl && m_cfg_ready(ch);
    run  = m_ready;
    m_lc = lk ? ((m_lc < LCY) ? m_lc + 1 : m_lc) : 0;
    nrdy = lk && (m_lc >= LCY);
    for (int c = 0; c < NCH; c++) begin
      m_ck[c] = 0;
      if (!run || sy || m_act[c] == 0) begin
        if (m_pv[c]) begin m_act[c] = m_pend[c]; m_pv[c] = 0; end
        m_tog[c] = 0;
        m_due[c] = t + 1 + m_act[c];
      end else if (m_due[c] == t + 1) begin
        m_ck[c]  = 1;
        m_tog[c] = !m_tog[c];
        if (m_pv[c]) begin m_act[c] = m_pend[c]; m_pv[c] = 0; end
        m_due[c] = t + 1 + m_act[c];
      end
      if (acc && ch == c) begin m_pend[c] = dv; m_pv[c] = 1; end
    end
    if (run && !nrdy) m_lol = 1;
    else if (acc && ch == (1 << CW) - 1 && dv == 0) m_lol = 0;
    m_ready = nrdy;
    t++;
  endtask

  task automatic step(input bit r, input bit lk, input bit sy, input bit vl,
                      input int unsigned ch, input int unsigned dv);
    exp_t e;
    int unsigned chm;
    chm = ch % (1 << CW);
    #1;
    rst              = r;
    lock             = lk;
    sync_s           = sy;
    cfg_if.CFG_VALID = vl;
    cfg_if.CFG_CH    = CW'(chm);
    cfg_if.CFG_DIV   = DW'(dv);
    e.ready = m_ready;
    for (int c = 0; c < NCH; c++) begin
      e.clken[c]  = m_ck[c] & m_ready;
      e.toggle[c] = m_tog[c] & m_ready;
    end
    e.cfg_ready = m_cfg_ready(chm);
`ifdef TRACKER_CLKGEN_LOCKMON_EN
    e.lol = m_lol;
`else
    e.lol = 1'b0;
`endif
    q.push_back(e);
    model_edge(r, lk, sy, vl, chm, dv);
    @(posedge clk);
  endtask

  task automatic idle(input int n, input bit lk, input int unsigned ch);
    for (int i = 0; i < n; i++) step(1'b0, lk, 1'b0, 1'b0, ch, 0);
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e, g;
    if (q.size() != 0) begin
      e = q.pop_front();
      g.ready     = ready;
      g.clken     = clken;
      g.toggle    = toggle;
      g.cfg_ready = cfg_if.CFG_READY;
`ifdef TRACKER_CLKGEN_LOCKMON_EN
      g.lol       = lol;
`else
      g.lol       = 1'b0;
`endif
      n_vec++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t READY got %b exp %b CLKEN got %b exp %b TOGGLE got %b exp %b CFG_READY got %b exp %b LOL got %b exp %b",
                 $time, g.ready, e.ready, g.clken, e.clken, g.toggle, e.toggle,
                 g.cfg_ready, e.cfg_ready, g.lol, e.lol);
      end
    end
  end

  initial begin
    bit lk, sy, vl, r;
    rst = 1'b1; lock = 1'b0; sync_s = 1'b0;
    cfg_if.CFG_VALID = 1'b0; cfg_if.CFG_CH = '0; cfg_if.CFG_DIV = '0;
    model_reset();
    @(posedge clk);

    // reset held with arbitrary inputs
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 15));

    // configure while unlocked; ch7 is out of range and must be dropped
    step(0, 0, 0, 1, 0, 5);
    step(0, 0, 0, 1, 1, 8);
    step(0, 0, 0, 1, 2, 6);
    step(0, 0, 0, 1, 3, 1);
    step(0, 0, 0, 1, 4, 0);
    step(0, 0, 0, 1, 5, 3);
    step(0, 0, 0, 1, 7, 9);
    idle(3, 0, 0);

    // lock for 200 cycles, drop, then full qualify into RUN
    idle(200, 1, 1);
    idle(1, 0, 1);
    idle(LCY + 40, 1, 1);

    // ratio change mid-period on ch1, watch its CFG_READY
    step(0, 1, 0, 1, 1, 3);
    step(0, 1, 0, 1, 1, 7);
    idle(30, 1, 1);

    // SYNC with a same-cycle write to ch0
    step(0, 1, 1, 1, 0, 2);
    idle(30, 1, 0);
    step(0, 1, 1, 0, 2, 0);
    idle(20, 1, 2);

    // loss of lock in RUN, relock, then clear-write on the all-ones channel
    idle(1, 0, 0);
    idle(LCY + 10, 1, 3);
    step(0, 1, 0, 1, 7, 0);
    idle(10, 1, 4);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      lk = ($urandom_range(0, 599) != 0);
      sy = ($urandom_range(0, 39) == 0);
      vl = ($urandom_range(0, 3) == 0);
      step(1'b0, lk, sy, vl, $urandom_range(0, 7), $urandom_range(0, 9));
    end

    // reset mid-period, then come back up
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(LCY + 20, 1, 0);
    for (int i = 0; i < 200; i++) begin
      r  = ($urandom_range(0, 149) == 0);
      vl = ($urandom_range(0, 2) == 0);
      step(r, 1'b1, 1'($urandom_range(0, 29) == 0), vl, $urandom_range(0, 7), $urandom_range(0, 6));
    end

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending got %0d required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tracker_clkgen.md
TRACKER_CLKGEN -- requirements
Module: tracker_clkgen

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent clock-enable channels (1..8).
REQ-002 Parameter DIV_W, default 16, divide-ratio width in bits.
REQ-003 Parameter LOCK_CYCLES, default 256, consecutive PLL_LOCK-high cycles required before READY.
REQ-004 REFERENCECLK  input  1  sole clock, PLL global output; all logic rising-edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 PLL_LOCK  input  1  raw PLL lock indication, already synchronous to REFERENCECLK.
REQ-007 CFG_VALID  input  1  divide-ratio write request.
REQ-008 CFG_READY  output  1  write accepted when CFG_VALID and CFG_READY both high.
REQ-009 CFG_CH  input  clog2(NUM_CH), min 1  target channel index.
REQ-010 CFG_DIV  input  DIV_W  new divide ratio; 0 disables the channel.
REQ-011 SYNC  input  1  single-cycle phase-realign strobe for all channels.
REQ-012 READY  output  1  lock qualified; channels running.
REQ-013 CLKEN  output  NUM_CH  per-channel one-cycle enable pulse at terminal count.
REQ-014 TOGGLE  output  NUM_CH  per-channel registered square wave, period 2*DIV cycles.

Function
REQ-015 Lock FSM states: WAIT_LOCK, QUALIFY, RUN; reset enters WAIT_LOCK.
REQ-016 WAIT_LOCK -> QUALIFY when PLL_LOCK=1; QUALIFY counter starts at 1 and increments each cycle PLL_LOCK=1.
REQ-017 QUALIFY -> RUN on the cycle the counter reaches LOCK_CYCLES; PLL_LOCK=0 in QUALIFY -> WAIT_LOCK, counter cleared.
REQ-018 RUN -> WAIT_LOCK on any cycle with PLL_LOCK=0; READY=1 only in RUN, registered.
REQ-019 Outside RUN: CLKEN=0, TOGGLE=0, all channel counters held at active DIV-1; configuration writes still accepted.
REQ-020 Per channel in RUN with active DIV>=2: down-counter from DIV-1; at 0, CLKEN pulses one cycle, TOGGLE inverts, counter reloads DIV-1.
REQ-021 Active DIV=1: CLKEN=1 every cycle, TOGGLE inverts every cycle.
REQ-022 Active DIV=0: CLKEN=0, TOGGLE=0, counter held at 0.
REQ-023 Each channel holds one pending slot; CFG_READY = NOT pending-valid[CFG_CH].
REQ-024 Accepted write stores CFG_DIV in the pending slot; CFG_CH >= NUM_CH is accepted and discarded.
REQ-025 Pending value becomes active on the channel's next terminal-count cycle (counter reload uses new value) or next cycle if active DIV=0 or not in RUN; slot then clears.
REQ-026 Ratio changes never shorten or lengthen a period already in progress (glitch-free).
REQ-027 SYNC in RUN: all pending values applied, all counters load (active DIV-1), TOGGLE cleared, no CLKEN that cycle.
REQ-028 SYNC and accepted write to same channel in same cycle: SYNC uses prior pending/active; new value held pending until next terminal count.
REQ-029 SYNC outside RUN is ignored.
REQ-030 First CLKEN after entering RUN occurs DIV cycles after READY rises (DIV>=2).

Reset
REQ-031 RESET clears: FSM to WAIT_LOCK, qualify counter 0, READY 0, CLKEN 0, TOGGLE 0, all active DIV 0, pending slots invalid, CFG_READY 1, LOL 0.
REQ-032 RESET asserted mid-period aborts all counting on the next edge; no partial pulse afterwards.

Configuration
REQ-033 Macro TRACKER_CLKGEN_LOCKMON_EN defined: extra output LOL (1 bit), set sticky on RUN->WAIT_LOCK transition, cleared only by RESET or an accepted write with CFG_CH=all-ones and CFG_DIV=0.
REQ-034 Macro undefined: no LOL port, no loss-of-lock logic; all-ones-channel write treated per REQ-024.

Structure
REQ-035 Shared package tracker_clk_pkg holds lock-FSM state enum, DIV_W default, LOCK_CYCLES default.
REQ-036 One sub-module tracker_clkgen_ch: single channel counter, pending slot, CLKEN/TOGGLE; instantiated NUM_CH times.

Verification
REQ-037 Lock: PLL_LOCK high from cycle 10 -> READY rises at cycle 10+256; drop at 200 cycles in -> READY 0 next cycle, restart full qualify.
REQ-038 Divide: ch0 DIV=5 in RUN -> CLKEN[0] period 5, TOGGLE[0] period 10, 50% duty.
REQ-039 Glitch-free: ch1 DIV=8, write DIV=3 mid-period -> current 8-cycle period completes, then 3-cycle periods; CFG_READY low for that channel until applied.
REQ-040 SYNC: ch0 DIV=4, ch2 DIV=6, SYNC -> both TOGGLE 0, next CLKEN at +4 and +6 cycles respectively.
REQ-041 Edge ratios: DIV=1 -> CLKEN constant 1; DIV=0 -> CLKEN/TOGGLE constant 0; write to CFG_CH=7 with NUM_CH=4 -> no channel changes.
REQ-042 LOCKMON: lose lock in RUN -> LOL=1 sticky after relock; clear-write -> LOL=0.
